datapath_hblur: RTL and testbench

DATAPATH_HBLUR -- requirements
Module: datapath_hblur

---
 rtl/datapath_hblur.sv | 140 ++++++++++++++
 tb/tb_datapath_hblur.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_hblur.sv
// Horizontal 3-tap [1 2 1]/4 blur over a raster row stream, with edge replication
// and a one-cycle flush stall at each row end.
module datapath_hblur #(
    parameter int C_ROW_SIZE = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       sof_in,
    output logic       busy_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sof_out,
    input  logic       busy_in
);

    localparam int CW = (C_ROW_SIZE > 2) ? $clog2(C_ROW_SIZE) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(C_ROW_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    left_q, left_d;
    logic [7:0]    cur_q, cur_d;
    logic          row_sof_q, row_sof_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_out_q, valid_out_d;
    logic          sof_out_q, sof_out_d;
    logic          accept_s;

    // 10-bit sum keeps the full range before the truncating divide by four
    function automatic logic [7:0] blur3(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
        logic [9:0] sum;
        sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
        return sum[9:2];
    endfunction

    assign busy_out = busy_in | (state_q == S_FLUSH);
    assign accept_s = valid_in & ~busy_out;

    // Next-state, datapath and output computation; everything holds while downstream stalls
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        left_d      = left_q;
        cur_d       = cur_q;
        row_sof_d   = row_sof_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        sof_out_d   = 1'b0;
        if (busy_in) begin
            valid_out_d = valid_out_q;
            sof_out_d   = sof_out_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        left_d    = data_in;
                        cur_d     = data_in;
                        row_sof_d = sof_in;
                        col_d     = CW'(1);
                        state_d   = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (accept_s && sof_in) begin
                        // A new frame abandons the partial row and restarts at column 0
                        left_d    = data_in;
                        cur_d     = data_in;
                        row_sof_d = 1'b1;
                        col_d     = CW'(1);
                    end else if (accept_s) begin
                        data_out_d  = blur3(left_q, cur_q, data_in);
                        valid_out_d = 1'b1;
                        sof_out_d   = row_sof_q;
                        row_sof_d   = 1'b0;
                        left_d      = cur_q;
                        cur_d       = data_in;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            state_d = S_FLUSH;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_FLUSH: begin
                    // Right neighbour of the last pixel is the pixel itself
                    data_out_d  = blur3(left_q, cur_q, cur_q);
                    valid_out_d = 1'b1;
                    sof_out_d   = 1'b0;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    col_d   = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            left_q      <= 8'd0;
            cur_q       <= 8'd0;
            row_sof_q   <= 1'b0;
            data_out_q  <= 8'd0;
            valid_out_q <= 1'b0;
            sof_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            left_q      <= left_d;
            cur_q       <= cur_d;
            row_sof_q   <= row_sof_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            sof_out_q   <= sof_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign sof_out   = sof_out_q;

endmodule

// File: tb/tb_datapath_hblur.sv
// Scoreboard bench for datapath_hblur: row-level reference model feeds an expected
// queue, a negedge monitor pops and compares every transferred output.
module tb_datapath_hblur;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       sof_in;
    logic       busy_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       sof_out;
    logic       busy_in;

    datapath_hblur #(.C_ROW_SIZE(N)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .sof_in   (sof_in),
        .busy_out (busy_out),
        .data_out (data_out),
        .valid_out(valid_out),
        .sof_out  (sof_out),
        .busy_in  (busy_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sof;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];
    exp_t out_log[$];
    int   row_q[$];
    bit   row_sof;
    int   nchecks = 0;
    int   nerr = 0;
    bit   rand_busy = 1'b0;
    bit   count_busy = 1'b0;
    int   busy_cycles = 0;
    bit   prev_busy = 1'b0;
    bit   prev_rst = 1'b1;
    exp_t prev_out;
    logic prev_valid;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pixel at index i of the current row with edge replication
    function automatic int px(input int i);
        int hi;
        hi = row_q.size() - 1;
        if (i < 0) return row_q[0];
        if (i > hi) return row_q[hi];
        return row_q[i];
    endfunction

    function automatic int ref_out(input int x);
        return (px(x - 1) + 2 * px(x) + px(x + 1)) / 4;
    endfunction

    task automatic model_accept(input int p, input bit s);
        exp_t e;
        int   k;
        if (s) begin
            row_q.delete();
            row_sof = 1'b1;
        end else if (row_q.size() == 0) begin
            row_sof = 1'b0;
        end
        row_q.push_back(p);
        k = row_q.size();
        if (k >= 2) begin
            e.sof = row_sof && (k == 2);
            e.d   = 8'(ref_out(k - 2));
            sb_q.push_back(e);
        end
        if (k == N) begin
            e.sof = 1'b0;
            e.d   = 8'(ref_out(N - 1));
            sb_q.push_back(e);
            row_q.delete();
        end
    endtask

    // Monitor: an output transfers at the next rising edge when valid_out && !busy_in
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !prev_rst && prev_busy) begin
            chk("hold_valid", int'(valid_out), int'(prev_valid));
            chk("hold_data", int'({sof_out, data_out}), int'(prev_out));
        end
        if (!rst && valid_out && !busy_in) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("data_out", int'(data_out), int'(e.d));
                chk("sof_out", int'(sof_out), int'(e.sof));
                out_log.push_back(exp_t'({sof_out, data_out}));
            end
        end
        if (count_busy && busy_out && !busy_in) busy_cycles++;
        prev_busy  = busy_in;
        prev_rst   = rst;
        prev_out   = exp_t'({sof_out, data_out});
        prev_valid = valid_out;
    end

    // Random downstream back-pressure for the soak phase
    always @(posedge clk) begin
        if (rand_busy) begin
            #1;
            busy_in = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic send(input int p, input bit s);
        bit done;
        done     = 1'b0;
        data_in  = 8'(p);
        sof_in   = s;
        valid_in = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (!busy_out) begin
                model_accept(p, s);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", sb_q.size(), 0);
    endtask

    task automatic check_log(input string name, input int exp[N], input int sof_idx);
        chk({name, "_count"}, out_log.size(), N);
        if (out_log.size() == N) begin
            for (int i = 0; i < N; i++) begin
                chk({name, "_val"}, int'(out_log[i].d), exp[i]);
                chk({name, "_sof"}, int'(out_log[i].sof), int'(i == sof_idx));
            end
        end
    endtask

    int ramp_exp[N]  = '{1, 4, 8, 12, 16, 20, 24, 27};
    int spike_exp[N] = '{0, 0, 63, 127, 63, 0, 0, 0};
    int spike_in[N]  = '{0, 0, 0, 255, 0, 0, 0, 0};

    initial begin
        rst      = 1'b1;
        busy_in  = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        data_in  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_sof_out", int'(sof_out), 0);
        chk("rst_busy_out_lo", int'(busy_out), 0);
        busy_in = 1'b1;
        #1;
        chk("rst_busy_out_hi", int'(busy_out), 1);
        busy_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp with sof on pixel 0
        out_log.delete();
        for (int i = 0; i < N; i++) send(4 * i, i == 0);
        drain();
        check_log("ramp", ramp_exp, 0);

        // Spike, row without sof
        out_log.delete();
        for (int i = 0; i < N; i++) send(spike_in[i], 1'b0);
        drain();
        check_log("spike", spike_exp, -1);

        // Two back-to-back constant rows: one flush stall per row
        out_log.delete();
        busy_cycles = 0;
        count_busy  = 1'b1;
        for (int i = 0; i < 2 * N; i++) send(100, i == 0);
        drain();
        count_busy = 1'b0;
        chk("const_count", out_log.size(), 2 * N);
        chk("const_busy_cycles", busy_cycles, 2);
        foreach (out_log[i]) chk("const_val", int'(out_log[i].d), 100);

        // Ramp with a 5-cycle downstream stall mid-row
        out_log.delete();
        for (int i = 0; i < 4; i++) send(4 * i, i == 0);
        busy_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        busy_in = 1'b0;
        for (int i = 4; i < N; i++) send(4 * i, 1'b0);
        drain();
        check_log("ramp_stall", ramp_exp, 0);

        // sof at column 4 abandons the partial row
        out_log.delete();
        for (int i = 0; i < 4; i++) send($urandom_range(0, 255), i == 0);
        for (int i = 0; i < N; i++) send($urandom_range(0, 255), i == 0);
        drain();
        chk("sof_mid_count", out_log.size(), 3 + N);
        if (out_log.size() > 3) chk("sof_mid_new_sof", int'(out_log[3].sof), 1);

        // Async reset at column 5, while out[4] is still presented
        for (int i = 0; i < 6; i++) send(4 * i + 3, i == 0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_data_out", int'(data_out), 0);
        chk("arst_valid_out", int'(valid_out), 0);
        chk("arst_sof_out", int'(sof_out), 0);
        sb_q.delete();
        row_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_log.delete();
        for (int i = 0; i < N; i++) send(4 * i, i == 0);
        drain();
        check_log("post_rst_ramp", ramp_exp, 0);

        // Random soak with back-pressure, gaps and occasional sof
        rand_busy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send($urandom_range(0, 255), (i == 0) || ($urandom_range(0, 19) == 0));
        end
        rand_busy = 1'b0;
        @(posedge clk);
        #2;
        busy_in = 1'b0;
        for (int i = 0; i < N; i++) send($urandom_range(0, 255), 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
